// File: rtl/exc_commit_if.sv
// Commit-to-CP0 exception write bundle plus the fetch redirect handshake.
// The master side is the commit unit. The slave side is CP0 and fetch.
interface exc_commit_if;
  logic        cp0w_we;
  logic        cp0w_bd;
  logic        cp0w_exl;
  logic [4:0]  cp0w_exc;
  logic [31:0] cp0w_epc;
  logic [31:0] cp0w_bva;
  logic        redir_valid;
  logic [31:0] redir_pc;
  logic        redir_ready;

  modport master (
    output cp0w_we, cp0w_bd, cp0w_exl, cp0w_exc, cp0w_epc, cp0w_bva,
    output redir_valid, redir_pc,
    input  redir_ready
  );

  modport slave (
    input  cp0w_we, cp0w_bd, cp0w_exl, cp0w_exc, cp0w_epc, cp0w_bva,
    input  redir_valid, redir_pc,
    output redir_ready
  );
endinterface

// File: rtl/exc_commit.sv
// Exception commit unit: arbitrates interrupts and faults at commit, writes CP0,
// flushes the pipeline and holds a fetch redirect until it is accepted.
module exc_commit #(
  parameter logic [31:0] EXC_VECTOR = 32'hBFC00380
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        mem_valid,
  input  logic        mem_stall,
  input  logic [31:0] mem_pc,
  input  logic        mem_bd,
  input  logic [31:0] mem_bva,
  input  logic        f_adel_if,
  input  logic        f_ri,
  input  logic        f_ov,
  input  logic        f_sys,
  input  logic        f_bp,
  input  logic        f_adel_ld,
  input  logic        f_ades_st,
  input  logic        f_eret,
  input  logic [7:0]  intr_vect,
  input  logic [31:0] er_epc,
  exc_commit_if.master bus,
  output logic        exl_clr,
  output logic        flush,
  output logic [31:0] exc_count
);
  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_REDIR = 1'b1;

  logic [0:0]  state_q, state_d;
  logic [31:0] redir_pc_q, redir_pc_d;
  logic [31:0] exc_count_q, exc_count_d;

  logic        accept;
  logic        sel_valid;
  logic        sel_addr;
  logic [4:0]  sel_code;
  logic        is_exc;
  logic        is_eret;

  assign accept = (state_q == ST_IDLE) && mem_valid && !mem_stall;

  // Priority chain: the interrupt sits above every synchronous fault and ERET.
  always_comb begin
    sel_valid = 1'b1;
    sel_addr  = 1'b0;
    sel_code  = 5'h00;
    if (intr_vect != 8'h00) begin
      sel_code = 5'h00;
    end else if (f_adel_if) begin
      sel_code = 5'h04;
      sel_addr = 1'b1;
    end else if (f_ri) begin
      sel_code = 5'h0A;
    end else if (f_ov) begin
      sel_code = 5'h0C;
    end else if (f_sys) begin
      sel_code = 5'h08;
    end else if (f_bp) begin
      sel_code = 5'h09;
    end else if (f_adel_ld) begin
      sel_code = 5'h04;
      sel_addr = 1'b1;
    end else if (f_ades_st) begin
      sel_code = 5'h05;
      sel_addr = 1'b1;
    end else begin
      sel_valid = 1'b0;
    end
  end

  assign is_exc  = accept && sel_valid;
  assign is_eret = accept && !sel_valid && f_eret;

  assign bus.cp0w_we  = is_exc;
  assign bus.cp0w_bd  = is_exc && mem_bd;
  assign bus.cp0w_exl = is_exc;
  assign bus.cp0w_exc = is_exc ? sel_code : 5'h00;
  assign bus.cp0w_epc = !is_exc ? 32'h0 : (mem_bd ? mem_pc - 32'd4 : mem_pc);
  assign bus.cp0w_bva = (is_exc && sel_addr) ? mem_bva : 32'h0;

  assign exl_clr         = is_eret;
  assign flush           = is_exc || is_eret || (state_q == ST_REDIR);
  assign bus.redir_valid = (state_q == ST_REDIR);
  assign bus.redir_pc    = redir_pc_q;
  assign exc_count       = exc_count_q;

  always_comb begin
    state_d     = state_q;
    redir_pc_d  = redir_pc_q;
    exc_count_d = exc_count_q + {31'd0, is_exc};
    if (is_exc) begin
      state_d    = ST_REDIR;
      redir_pc_d = EXC_VECTOR;
    end else if (is_eret) begin
      state_d    = ST_REDIR;
      redir_pc_d = er_epc;
    end else if ((state_q == ST_REDIR) && bus.redir_ready) begin
      state_d = ST_IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      redir_pc_q  <= 32'h0;
      exc_count_q <= 32'h0;
    end else begin
      state_q     <= state_d;
      redir_pc_q  <= redir_pc_d;
      exc_count_q <= exc_count_d;
    end
  end
endmodule

// File: tb/tb_exc_commit.sv
// Directed bench for exc_commit: inputs change 1ns after a rising edge,
// and outputs are checked before the next rising edge.
module tb_exc_commit;
  logic        clk = 1'b0;
  logic        rst;
  logic        mem_valid, mem_stall, mem_bd;
  logic [31:0] mem_pc, mem_bva, er_epc;
  logic        f_adel_if, f_ri, f_ov, f_sys, f_bp, f_adel_ld, f_ades_st, f_eret;
  logic [7:0]  intr_vect;
  logic        exl_clr, flush;
  logic [31:0] exc_count;
  int          checks = 0;
  int          errors = 0;

  exc_commit_if bus_if ();

  exc_commit dut (
    .clk(clk), .rst(rst),
    .mem_valid(mem_valid), .mem_stall(mem_stall), .mem_pc(mem_pc),
    .mem_bd(mem_bd), .mem_bva(mem_bva),
    .f_adel_if(f_adel_if), .f_ri(f_ri), .f_ov(f_ov), .f_sys(f_sys),
    .f_bp(f_bp), .f_adel_ld(f_adel_ld), .f_ades_st(f_ades_st), .f_eret(f_eret),
    .intr_vect(intr_vect), .er_epc(er_epc),
    .bus(bus_if.master),
    .exl_clr(exl_clr), .flush(flush), .exc_count(exc_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h exp %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic clr();
    mem_valid = 0; mem_stall = 0; mem_bd = 0; mem_pc = 0; mem_bva = 0;
    f_adel_if = 0; f_ri = 0; f_ov = 0; f_sys = 0; f_bp = 0;
    f_adel_ld = 0; f_ades_st = 0; f_eret = 0; intr_vect = 0;
  endtask

  task automatic check_exc(input string tag, input logic [4:0] code, input logic [31:0] epc,
                           input logic [31:0] bva, input logic bd);
    check({tag, ".we"},    {31'd0, bus_if.cp0w_we}, 32'd1);
    check({tag, ".exc"},   {27'd0, bus_if.cp0w_exc}, {27'd0, code});
    check({tag, ".epc"},   bus_if.cp0w_epc, epc);
    check({tag, ".bva"},   bus_if.cp0w_bva, bva);
    check({tag, ".bd"},    {31'd0, bus_if.cp0w_bd}, {31'd0, bd});
    check({tag, ".exl"},   {31'd0, bus_if.cp0w_exl}, 32'd1);
    check({tag, ".flush"}, {31'd0, flush}, 32'd1);
  endtask

  // Checks the first REDIR cycle, then lets fetch accept it.
  task automatic redir_exit(input string tag, input logic [31:0] pc, input logic [31:0] cnt);
    clr();
    #1;
    check({tag, ".rvalid"}, {31'd0, bus_if.redir_valid}, 32'd1);
    check({tag, ".rpc"},    bus_if.redir_pc, pc);
    check({tag, ".rflush"}, {31'd0, flush}, 32'd1);
    check({tag, ".rwe"},    {31'd0, bus_if.cp0w_we}, 32'd0);
    check({tag, ".count"},  exc_count, cnt);
    bus_if.redir_ready = 1;
    step();
    bus_if.redir_ready = 0;
    #1;
    check({tag, ".xvalid"}, {31'd0, bus_if.redir_valid}, 32'd0);
    check({tag, ".xflush"}, {31'd0, flush}, 32'd0);
  endtask

  initial begin
    rst = 1; clr(); er_epc = 0; bus_if.redir_ready = 0;
    repeat (2) step();
    rst = 0;
    #1;
    $display("txn reset");
    check("rst.we", {31'd0, bus_if.cp0w_we}, 32'd0);
    check("rst.epc", bus_if.cp0w_epc, 32'd0);
    check("rst.flush", {31'd0, flush}, 32'd0);
    check("rst.exl_clr", {31'd0, exl_clr}, 32'd0);
    check("rst.rvalid", {31'd0, bus_if.redir_valid}, 32'd0);
    check("rst.rpc", bus_if.redir_pc, 32'd0);
    check("rst.count", exc_count, 32'd0);

    $display("txn overflow");
    mem_valid = 1; mem_pc = 32'h80001000; f_ov = 1;
    #1;
    check_exc("ov", 5'h0C, 32'h80001000, 32'h0, 1'b0);
    step();
    redir_exit("ov", 32'hBFC00380, 32'd1);

    $display("txn delay-slot load error");
    mem_valid = 1; mem_pc = 32'h80002004; mem_bd = 1; f_adel_ld = 1; mem_bva = 32'h3;
    #1;
    check_exc("adel", 5'h04, 32'h80002000, 32'h3, 1'b1);
    step();
    redir_exit("adel", 32'hBFC00380, 32'd2);

    $display("txn interrupt vs syscall");
    mem_valid = 1; mem_pc = 32'h80004000; intr_vect = 8'h04; f_sys = 1; mem_bva = 32'h55;
    #1;
    check_exc("irq", 5'h00, 32'h80004000, 32'h0, 1'b0);
    step();
    redir_exit("irq", 32'hBFC00380, 32'd3);

    $display("txn interrupt under stall");
    mem_valid = 1; mem_pc = 32'h80004010; intr_vect = 8'h04; f_sys = 1; mem_stall = 1;
    for (int i = 0; i < 3; i++) begin
      #1;
      check("stall.we", {31'd0, bus_if.cp0w_we}, 32'd0);
      check("stall.flush", {31'd0, flush}, 32'd0);
      step();
    end
    mem_stall = 0;
    #1;
    check_exc("stall_rel", 5'h00, 32'h80004010, 32'h0, 1'b0);
    step();
    redir_exit("stall_rel", 32'hBFC00380, 32'd4);

    $display("txn interrupt dropped during stall");
    mem_valid = 1; mem_pc = 32'h80004020; intr_vect = 8'h01; mem_stall = 1;
    step();
    intr_vect = 0; mem_stall = 0;
    #1;
    check("drop.we", {31'd0, bus_if.cp0w_we}, 32'd0);
    check("drop.flush", {31'd0, flush}, 32'd0);
    step();
    check("drop.rvalid", {31'd0, bus_if.redir_valid}, 32'd0);
    check("drop.count", exc_count, 32'd4);

    $display("txn eret");
    clr();
    mem_valid = 1; mem_pc = 32'h80005000; f_eret = 1; er_epc = 32'h80003010;
    #1;
    check("eret.exl_clr", {31'd0, exl_clr}, 32'd1);
    check("eret.flush", {31'd0, flush}, 32'd1);
    check("eret.we", {31'd0, bus_if.cp0w_we}, 32'd0);
    step();
    // Inputs arriving during REDIR must be ignored and EPC must not be re-sampled.
    clr();
    er_epc = 32'h12345678; mem_valid = 1; f_ov = 1; intr_vect = 8'h80;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("eret.hold_rvalid", {31'd0, bus_if.redir_valid}, 32'd1);
      check("eret.hold_rpc", bus_if.redir_pc, 32'h80003010);
      check("eret.hold_flush", {31'd0, flush}, 32'd1);
      check("eret.hold_we", {31'd0, bus_if.cp0w_we}, 32'd0);
      check("eret.hold_exl_clr", {31'd0, exl_clr}, 32'd0);
      step();
    end
    clr();
    bus_if.redir_ready = 1;
    step();
    bus_if.redir_ready = 0;
    #1;
    check("eret.xvalid", {31'd0, bus_if.redir_valid}, 32'd0);
    check("eret.xflush", {31'd0, flush}, 32'd0);
    check("eret.count", exc_count, 32'd4);

    $display("txn no flags");
    mem_valid = 1; mem_pc = 32'h80006000;
    #1;
    check("none.we", {31'd0, bus_if.cp0w_we}, 32'd0);
    check("none.flush", {31'd0, flush}, 32'd0);
    step();
    check("none.rvalid", {31'd0, bus_if.redir_valid}, 32'd0);

    $display("txn reset mid-redirect");
    clr();
    mem_valid = 1; mem_pc = 32'h80007000; f_ri = 1;
    #1;
    check_exc("ri", 5'h0A, 32'h80007000, 32'h0, 1'b0);
    step();
    clr();
    step();
    check("ri.rvalid2", {31'd0, bus_if.redir_valid}, 32'd1);
    rst = 1;
    step();
    rst = 0;
    #1;
    check("mrst.rvalid", {31'd0, bus_if.redir_valid}, 32'd0);
    check("mrst.rpc", bus_if.redir_pc, 32'd0);
    check("mrst.flush", {31'd0, flush}, 32'd0);
    check("mrst.count", exc_count, 32'd0);
    check("mrst.we", {31'd0, bus_if.cp0w_we}, 32'd0);
    mem_valid = 1; mem_pc = 32'h80008000; f_bp = 1;
    #1;
    check_exc("bp", 5'h09, 32'h80008000, 32'h0, 1'b0);
    step();
    redir_exit("bp", 32'hBFC00380, 32'd1);

    $display("txn counter wrap");
    @(negedge clk);
    force dut.exc_count_q = 32'hFFFFFFFF;
    #1;
    release dut.exc_count_q;
    step();
    check("wrap.pre", exc_count, 32'hFFFFFFFF);
    mem_valid = 1; mem_pc = 32'h80009000; f_ades_st = 1; mem_bva = 32'h80009002;
    #1;
    check_exc("ades", 5'h05, 32'h80009000, 32'h80009002, 1'b0);
    step();
    redir_exit("ades", 32'hBFC00380, 32'h00000000);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule

// File: doc/exc_commit.md
Name: exc_commit

Overview:
- Exception commit unit at the MEM/commit boundary of the MIPS pipeline.
- Drives the CP0 exception-write bundle (reg_error: we, bd, exl, exc, epc, bva), consuming intr_vect and er_epc from CP0.
- Arbitrates pending interrupts and synchronous exceptions of the committing instruction, flushes the pipeline and redirects fetch to the handler or, for ERET, to EPC via a valid/ready handshake.

Parameters:
- EXC_VECTOR, 32'hBFC00380, handler entry PC.

Ports:
- clk  in  1  clock
- rst  in  1  synchronous active-high reset
- mem_valid  in  1  committing instruction present
- mem_stall  in  1  commit stage stalled; no acceptance
- mem_pc  in  32  PC of committing instruction
- mem_bd  in  1  instruction is in a branch delay slot
- mem_bva  in  32  faulting address (fetch or data)
- f_adel_if  in  1  fetch address error
- f_ri  in  1  reserved instruction
- f_ov  in  1  arithmetic overflow
- f_sys  in  1  syscall
- f_bp  in  1  break
- f_adel_ld  in  1  load address error
- f_ades_st  in  1  store address error
- f_eret  in  1  ERET instruction
- intr_vect  in  8  masked pending interrupts from CP0
- er_epc  in  32  current EPC from CP0
- cp0w  out  reg_error  exception write bundle to CP0
- exl_clr  out  1  one-cycle EXL clear pulse on ERET
- flush  out  1  discard all instructions younger than commit
- redir_valid  out  1  redirect request to fetch
- redir_pc  out  32  redirect target
- redir_ready  in  1  fetch accepts redirect
- exc_count  out  32  count of accepted exceptions/interrupts

Behaviour:
- States: IDLE, REDIR.
- Reset: state IDLE, cp0w all fields 0, exl_clr=0, flush=0, redir_valid=0, redir_pc=0, exc_count=0. Reset takes effect from any state, including REDIR mid-handshake.
- Acceptance condition: state IDLE, mem_valid=1 and mem_stall=0.
- Event selection, highest priority first:
  - interrupt (intr_vect!=0, exc 0x00)
  - f_adel_if (0x04)
  - f_ri (0x0A)
  - f_ov (0x0C)
  - f_sys (0x08)
  - f_bp (0x09)
  - f_adel_ld (0x04)
  - f_ades_st (0x05)
  - f_eret
- Exception/interrupt accepted in cycle T (combinational in T):
  - cp0w.we=1, bd=mem_bd, exl=1, exc=selected code.
  - epc = mem_bd ? mem_pc-4 : mem_pc (32-bit wrap).
  - bva = mem_bva for address errors, else 0.
  - flush=1.
- ERET accepted in T: cp0w.we=0, exl_clr=1, flush=1.
- Cycle T+1: state REDIR, redir_valid=1.
  - redir_pc = EXC_VECTOR for an exception, or er_epc sampled at T for ERET.
  - redir_pc and flush remain held steady until redir_ready=1.
- REDIR:
  - cp0w.we=0; all mem_* and f_* inputs ignored; intr_vect is not taken.
  - On redir_valid & redir_ready: next cycle IDLE with flush=0 and redir_valid=0.
  - Ready in the first REDIR cycle gives a 1-cycle REDIR.
- exc_count increments by 1 (32-bit wrap) in each cycle that cp0w.we=1; ERET does not count.
- Outside acceptance, cp0w fields are 0.
- Interrupt with a simultaneous synchronous fault or ERET: the interrupt wins and epc is that instruction's PC (delay slot adjusted).
- Interrupt arriving during mem_stall: held off until the stall releases. If intr_vect drops before then, nothing is taken.
- No exception flags with mem_valid=1: no action; cp0w.we=0, flush=0.

Test Plan:
- Overflow: mem_pc=0x80001000, f_ov=1, bd=0 -> T: cp0w.we=1, exc=0x0C, epc=0x80001000, exl=1, flush=1. T+1: redir_valid=1, redir_pc=0xBFC00380. exc_count=1.
- Delay-slot load error: pc=0x80002004, bd=1, f_adel_ld=1, bva=0x00000003 -> exc=0x04, epc=0x80002000, bva=0x3, bd=1.
- Interrupt vs syscall: intr_vect=0x04, f_sys=1 -> exc=0x00, epc=mem_pc. Repeat with mem_stall=1 for 3 cycles -> no cp0w.we until the stall drops.
- ERET: er_epc=0x80003010, f_eret=1 -> exl_clr pulse, flush=1, cp0w.we=0. redir_pc=0x80003010 held for 4 cycles with redir_ready=0. Exit one cycle after ready; exc_count unchanged.
- Reset mid-REDIR: rst in second REDIR cycle -> next cycle all outputs 0, state IDLE. A new f_bp is accepted immediately after reset.
- Counter wrap: preload via 2^32 accepted events (or force internal register) -> exc_count wraps 0xFFFFFFFF -> 0x00000000.
